// File: rtl/character_transmission.sv
// UART-lite transmitter: idles low, high start bit, LSB-first data, low stop bit(s).
// Each bit lasts OVERSAMPLING clocks; one character is accepted per valid/ready handshake.
module character_transmission #(
  parameter int unsigned OVERSAMPLING = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DATA_BITS-1:0] char_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 tx_o,
  output logic                 busy_o
);

  localparam int unsigned CNT_W = (OVERSAMPLING > 1) ? $clog2(OVERSAMPLING) : 1;
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
  localparam int unsigned STP_W = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(OVERSAMPLING - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);
  localparam logic [STP_W-1:0] STP_LAST   = STP_W'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               r_state, w_state_next;
  logic [CNT_W-1:0]     r_cnt, w_cnt_next;
  logic [IDX_W-1:0]     r_idx, w_idx_next;
  logic [STP_W-1:0]     r_stop, w_stop_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic                 r_tx, w_tx_next;
  logic                 w_handshake;
  logic                 w_bit_done;
  logic [DATA_BITS-1:0] w_shift_rsh;

  assign ready_o     = (r_state == S_IDLE) && rst_ni;
  assign busy_o      = (r_state != S_IDLE);
  assign tx_o        = r_tx;
  assign w_handshake = valid_i && ready_o;
  assign w_bit_done  = (r_cnt == '0);
  assign w_shift_rsh = r_shift >> 1;

  // Next-state, counter, index and line-level decode for the frame sequencer
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_stop_next  = r_stop;
    w_shift_next = r_shift;
    w_tx_next    = r_tx;
    case (r_state)
      S_IDLE: begin
        if (w_handshake) begin
          w_state_next = S_START;
          w_cnt_next   = CNT_RELOAD;
          w_shift_next = char_i;
          w_tx_next    = 1'b1;
        end else begin
          w_tx_next    = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_done) begin
          w_state_next = S_DATA;
          w_cnt_next   = CNT_RELOAD;
          w_idx_next   = '0;
          w_tx_next    = r_shift[0];
        end else begin
          w_cnt_next   = r_cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (w_bit_done) begin
          w_cnt_next = CNT_RELOAD;
          if (r_idx == IDX_LAST) begin
            w_state_next = S_STOP;
            w_stop_next  = '0;
            w_tx_next    = 1'b0;
          end else begin
            w_shift_next = w_shift_rsh;
            w_tx_next    = w_shift_rsh[0];
            w_idx_next   = r_idx + 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_STOP: begin
        // Stop periods are counted separately so each reuses the bit counter
        if (w_bit_done) begin
          if (r_stop == STP_LAST) begin
            w_state_next = S_IDLE;
          end else begin
            w_stop_next  = r_stop + 1'b1;
            w_cnt_next   = CNT_RELOAD;
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
        w_tx_next    = 1'b0;
      end
    endcase
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_stop  <= '0;
      r_tx    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_stop  <= w_stop_next;
      r_tx    <= w_tx_next;
    end
  end

  // Data shift register; contents are don't-care until the next handshake
  always_ff @(posedge clk_i) begin
    r_shift <= w_shift_next;
  end

endmodule
